// File: rtl/frvp_spi_tl_ram_responder.sv
// rtl/frvp_spi_tl_ram_responder.sv - TileLink-UL register-array responder with response queue.
// Optional TL_RESP_DENIED_EN adds auto_in_d_bits_denied for rejected requests.
module frvp_spi_tl_ram_responder #(
  parameter int ADDR_W = 29,
  parameter int SOURCE_W = 6,
  parameter int DEPTH_WORDS = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int RESP_DEPTH = 2
) (
  input  logic                clock,
  input  logic                reset,
  output logic                auto_in_a_ready,
  input  logic                auto_in_a_valid,
  input  logic [2:0]          auto_in_a_bits_opcode,
  input  logic [2:0]          auto_in_a_bits_param,
  input  logic [1:0]          auto_in_a_bits_size,
  input  logic [SOURCE_W-1:0] auto_in_a_bits_source,
  input  logic [ADDR_W-1:0]   auto_in_a_bits_address,
  input  logic [3:0]          auto_in_a_bits_mask,
  input  logic [31:0]         auto_in_a_bits_data,
  input  logic                auto_in_a_bits_corrupt,
  input  logic                auto_in_d_ready,
  output logic                auto_in_d_valid,
  output logic [2:0]          auto_in_d_bits_opcode,
  output logic [1:0]          auto_in_d_bits_size,
  output logic [SOURCE_W-1:0] auto_in_d_bits_source,
`ifdef TL_RESP_DENIED_EN
  output logic                auto_in_d_bits_denied,
`endif
  output logic [31:0]         auto_in_d_bits_data
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(DEPTH_WORDS * 4);

  logic [31:0]         mem [DEPTH_WORDS];
  logic [2:0]          q_op   [RESP_DEPTH];
  logic [1:0]          q_size [RESP_DEPTH];
  logic [SOURCE_W-1:0] q_src  [RESP_DEPTH];
  logic [31:0]         q_data [RESP_DEPTH];
  logic                q_den  [RESP_DEPTH];
  logic                wr_ptr, rd_ptr;
  logic [1:0]          count;

  logic              a_fire, d_fire, is_get, is_put, in_range, ok, wr_en, denied;
  logic [ADDR_W-1:0] off;
  logic [IW-1:0]     idx;
  logic [31:0]       rd_word;
  logic              unused_param;

  assign unused_param = ^auto_in_a_bits_param;

  assign auto_in_a_ready = (count < 2'(RESP_DEPTH));
  assign auto_in_d_valid = (count != 2'd0);
  assign a_fire = auto_in_a_valid & auto_in_a_ready;
  assign d_fire = auto_in_d_valid & auto_in_d_ready;

  always_comb begin
    off      = auto_in_a_bits_address - BASE_ADDR;
    in_range = (auto_in_a_bits_address >= BASE_ADDR) && (off < SPAN);
    idx      = off[IW+1:2];
    is_get   = (auto_in_a_bits_opcode == 3'd4);
    is_put   = (auto_in_a_bits_opcode == 3'd0) || (auto_in_a_bits_opcode == 3'd1);
    ok       = in_range && (auto_in_a_bits_size != 2'd3) && (is_get || is_put);
    wr_en    = a_fire && ok && is_put && !auto_in_a_bits_corrupt;
    denied   = !ok || (is_put && auto_in_a_bits_corrupt);
    rd_word  = (ok && is_get) ? mem[idx] : 32'd0;
  end

  function automatic logic nxt(input logic p);
    return (RESP_DEPTH == 1) ? 1'b0 : ~p;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < RESP_DEPTH; i++) begin
        q_op[i]   <= 3'd0;
        q_size[i] <= 2'd0;
        q_src[i]  <= '0;
        q_data[i] <= 32'd0;
        q_den[i]  <= 1'b0;
      end
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
    end else begin
      if (wr_en) begin
        for (int b = 0; b < 4; b++)
          if (auto_in_a_bits_mask[b]) mem[idx][8*b +: 8] <= auto_in_a_bits_data[8*b +: 8];
      end
      // Read sees the array before this edge's write, so the response carries pre-write data
      if (a_fire) begin
        q_op[wr_ptr]   <= is_get ? 3'd1 : 3'd0;
        q_size[wr_ptr] <= auto_in_a_bits_size;
        q_src[wr_ptr]  <= auto_in_a_bits_source;
        q_data[wr_ptr] <= rd_word;
        q_den[wr_ptr]  <= denied;
        wr_ptr         <= nxt(wr_ptr);
      end
      if (d_fire) rd_ptr <= nxt(rd_ptr);
      case ({a_fire, d_fire})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign auto_in_d_bits_opcode = q_op[rd_ptr];
  assign auto_in_d_bits_size   = q_size[rd_ptr];
  assign auto_in_d_bits_source = q_src[rd_ptr];
  assign auto_in_d_bits_data   = q_data[rd_ptr];
`ifdef TL_RESP_DENIED_EN
  assign auto_in_d_bits_denied = q_den[rd_ptr];
`else
  logic unused_den;
  assign unused_den = q_den[rd_ptr];
`endif

endmodule

// File: tb/tb_frvp_spi_tl_ram_responder.sv
// tb/tb_frvp_spi_tl_ram_responder.sv - Scoreboard bench for frvp_spi_tl_ram_responder.
module tb_frvp_spi_tl_ram_responder;

  localparam logic [28:0] BASE = 29'h0;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [5:0]  src;
    logic [31:0] data;
    logic        den;
  } resp_t;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_ready, a_valid = 1'b0;
  logic [2:0]  a_op = '0, a_param = '0;
  logic [1:0]  a_size = '0;
  logic [5:0]  a_src = '0;
  logic [28:0] a_addr = '0;
  logic [3:0]  a_mask = '0;
  logic [31:0] a_data = '0;
  logic        a_corrupt = 1'b0;
  logic        d_ready = 1'b1, d_valid;
  logic [2:0]  d_op;
  logic [1:0]  d_size;
  logic [5:0]  d_src;
  logic [31:0] d_data;
  logic        d_denied;

  int checks = 0, failures = 0, resp_cnt = 0, cnt0;
  resp_t sb[$];
  resp_t head;
  logic [31:0] model [16];

  frvp_spi_tl_ram_responder dut (
    .clock(clock), .reset(rst_n),
    .auto_in_a_ready(a_ready), .auto_in_a_valid(a_valid),
    .auto_in_a_bits_opcode(a_op), .auto_in_a_bits_param(a_param),
    .auto_in_a_bits_size(a_size), .auto_in_a_bits_source(a_src),
    .auto_in_a_bits_address(a_addr), .auto_in_a_bits_mask(a_mask),
    .auto_in_a_bits_data(a_data), .auto_in_a_bits_corrupt(a_corrupt),
    .auto_in_d_ready(d_ready), .auto_in_d_valid(d_valid),
    .auto_in_d_bits_opcode(d_op), .auto_in_d_bits_size(d_size),
    .auto_in_d_bits_source(d_src),
`ifdef TL_RESP_DENIED_EN
    .auto_in_d_bits_denied(d_denied),
`endif
    .auto_in_d_bits_data(d_data)
  );

`ifndef TL_RESP_DENIED_EN
  assign d_denied = 1'b0;
`endif

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic resp_t predict(input logic [2:0] op, input logic [1:0] size, input logic [5:0] src,
                                    input logic [28:0] addr, input logic [3:0] mask,
                                    input logic [31:0] data, input logic corrupt);
    resp_t r;
    logic inr, good, put;
    logic [3:0] ix;
    inr  = (addr >= BASE) && (addr < BASE + 29'd64);
    put  = (op == 3'd0) || (op == 3'd1);
    good = inr && (size != 2'd3) && (put || op == 3'd4);
    ix   = addr[5:2];
    r.op   = (op == 3'd4) ? 3'd1 : 3'd0;
    r.size = size;
    r.src  = src;
    r.data = (good && op == 3'd4) ? model[ix] : 32'd0;
    r.den  = !good || (put && corrupt);
    if (good && put && !corrupt)
      for (int b = 0; b < 4; b++) if (mask[b]) model[ix][8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  task automatic drive_a(input logic [2:0] op, input logic [1:0] size, input logic [5:0] src,
                         input logic [28:0] addr, input logic [3:0] mask, input logic [31:0] data,
                         input logic corrupt);
    a_valid = 1'b1; a_op = op; a_size = size; a_src = src;
    a_addr = addr; a_mask = mask; a_data = data; a_corrupt = corrupt;
  endtask

  // Waits for acceptance of the driven request; leaves a_valid high for back-to-back use
  task automatic wait_accept();
    int n = 0;
    forever begin
      @(negedge clock);
      if (a_ready) begin
        sb.push_back(predict(a_op, a_size, a_src, a_addr, a_mask, a_data, a_corrupt));
        @(posedge clock); #1;
        break;
      end
      @(posedge clock); #1;
      n++;
      if (n > 20) begin
        chk("accept_timeout", 32'(n), 32'd0);
        break;
      end
    end
  endtask

  task automatic req(input logic [2:0] op, input logic [1:0] size, input logic [5:0] src,
                     input logic [28:0] addr, input logic [3:0] mask, input logic [31:0] data,
                     input logic corrupt);
    drive_a(op, size, src, addr, mask, data, corrupt);
    wait_accept();
  endtask

  task automatic idle(input int n);
    a_valid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (rst_n && d_valid && d_ready) begin
      resp_cnt++;
      chk("unexpected_resp", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        head = sb.pop_front();
        chk("d_opcode", 32'(d_op), 32'(head.op));
        chk("d_size", 32'(d_size), 32'(head.size));
        chk("d_source", 32'(d_src), 32'(head.src));
        chk("d_data", d_data, head.data);
`ifdef TL_RESP_DENIED_EN
        chk("d_denied", 32'(d_denied), 32'(head.den));
`endif
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    #12 rst_n = 1'b1;
    @(posedge clock); #1;
    chk("rst_d_valid", 32'(d_valid), 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd1);
    chk("rst_d_opcode", 32'(d_op), 32'd0);
    chk("rst_d_source", 32'(d_src), 32'd0);
    chk("rst_d_data", d_data, 32'd0);
    chk("rst_d_denied", 32'(d_denied), 32'd0);

    // Put then back-to-back Get of the same word, D one cycle after each fire
    req(3'd0, 2'd2, 6'd5, BASE + 29'd4, 4'hF, 32'hDEADBEEF, 1'b0);
    chk("lat_put_d_valid", 32'(d_valid), 32'd1);
    req(3'd4, 2'd2, 6'd5, BASE + 29'd4, 4'hF, 32'h0, 1'b0);
    chk("lat_get_d_valid", 32'(d_valid), 32'd1);
    idle(2);

    req(3'd1, 2'd2, 6'd7, BASE + 29'd4, 4'b0101, 32'h11223344, 1'b0);
    req(3'd4, 2'd2, 6'd8, BASE + 29'd4, 4'hF, 32'h0, 1'b0);
    idle(2);
    chk("partial_model", model[1], 32'hDE22BE44);

    for (int i = 0; i < 8; i++)
      req(3'd0, 2'd2, 6'(i), BASE + 29'(4 * (i + 2)), 4'hF, $urandom, 1'b0);
    idle(3);
    cnt0 = resp_cnt;
    for (int i = 0; i < 8; i++) begin
      drive_a(3'd4, 2'd2, 6'(20 + i), BASE + 29'(4 * (i + 2)), 4'hF, 32'h0, 1'b0);
      chk("b2b_a_ready", 32'(a_ready), 32'd1);
      wait_accept();
    end
    a_valid = 1'b0;
    @(posedge clock); #1;
    chk("b2b_resp_count", 32'(resp_cnt - cnt0), 32'd8);
    chk("b2b_drained", 32'(d_valid), 32'd0);

    // Backpressure: two queued, third held off until a slot frees
    d_ready = 1'b0;
    req(3'd4, 2'd2, 6'd40, BASE + 29'd8, 4'hF, 32'h0, 1'b0);
    req(3'd4, 2'd2, 6'd41, BASE + 29'd12, 4'hF, 32'h0, 1'b0);
    drive_a(3'd4, 2'd2, 6'd42, BASE + 29'd16, 4'hF, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("full_a_ready", 32'(a_ready), 32'd0);
      chk("hold_d_valid", 32'(d_valid), 32'd1);
      chk("hold_d_source", 32'(d_src), 32'(sb[0].src));
      chk("hold_d_data", d_data, sb[0].data);
    end
    @(posedge clock); #1;
    d_ready = 1'b1;
    @(negedge clock);
    chk("drain_cycle_a_ready", 32'(a_ready), 32'd0);
    @(posedge clock); #1;
    wait_accept();
    idle(4);

    // Error responses and suppressed writes
    req(3'd4, 2'd2, 6'd50, BASE + 29'd64, 4'hF, 32'h0, 1'b0);
    req(3'd4, 2'd3, 6'd51, BASE + 29'd4, 4'hF, 32'h0, 1'b0);
    req(3'd2, 2'd2, 6'd52, BASE + 29'd4, 4'hF, 32'hFFFFFFFF, 1'b0);
    req(3'd0, 2'd2, 6'd53, BASE + 29'd4, 4'hF, 32'h55555555, 1'b1);
    req(3'd0, 2'd3, 6'd54, BASE + 29'd4, 4'hF, 32'h66666666, 1'b0);
    req(3'd4, 2'd2, 6'd55, BASE + 29'd4, 4'hF, 32'h0, 1'b0);
    req(3'd0, 2'd0, 6'd56, BASE + 29'd60, 4'b1000, 32'hA5000000, 1'b0);
    req(3'd4, 2'd2, 6'd57, BASE + 29'd60, 4'hF, 32'h0, 1'b0);
    idle(4);

    // Reset with two responses in flight
    d_ready = 1'b0;
    req(3'd4, 2'd2, 6'd60, BASE + 29'd4, 4'hF, 32'h0, 1'b0);
    req(3'd4, 2'd2, 6'd61, BASE + 29'd8, 4'hF, 32'h0, 1'b0);
    a_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_d_valid", 32'(d_valid), 32'd0);
    sb.delete();
    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    d_ready = 1'b1;
    repeat (2) @(posedge clock);
    #3 rst_n = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_a_ready", 32'(a_ready), 32'd1);
    req(3'd4, 2'd2, 6'd62, BASE + 29'd4, 4'hF, 32'h0, 1'b0);
    req(3'd4, 2'd2, 6'd63, BASE + 29'd8, 4'hF, 32'h0, 1'b0);
    idle(4);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
